// File: rtl/addern_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Segment arithmetic is sized to SEG_MAX; callers zero-extend their narrower segments.
package addern_pkg;

  localparam int SEG_MAX = 64;

  // Returns {carry, sum} for a zero-extended segment plus carry-in.
  function automatic logic [SEG_MAX:0] seg_add(
    input logic [SEG_MAX-1:0] a_seg,
    input logic [SEG_MAX-1:0] b_seg,
    input logic               c
  );
    return {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_MAX{1'b0}}, c};
  endfunction

  function automatic bit params_ok(input int n, input int seg);
    return (seg >= 1) && (seg <= SEG_MAX) && (n >= seg) && ((n % seg) == 0);
  endfunction

endpackage

// File: rtl/addern_pipe_if.sv
// Operand/result handshake bundle for addern_pipe.
// master drives operands and consumes results; slave is the adder.
interface addern_pipe_if #(parameter int N = 16) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         overflow;
  logic         ovf_clr;
  logic         ovf_sticky;

  modport master (
    output in_valid, a, b, cin, sub, out_ready, ovf_clr,
    input  in_ready, out_valid, s, cout, overflow, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready, ovf_clr,
    output in_ready, out_valid, s, cout, overflow, ovf_sticky
  );

endinterface

// File: rtl/addern_seg.sv
// One pipeline stage: adds segment K of the travelling operands and forwards the carry.
// Lower segments of a_vec already hold finished sum bits; upper segments are untouched operands.
module addern_seg
  import addern_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 8,
  parameter int K   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_c,
  input  logic         in_amsb,
  input  logic         in_bmsb,
  input  logic         in_sub,
  output logic         out_valid,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic         out_c,
  output logic         out_amsb,
  output logic         out_bmsb,
  output logic         out_sub
);

  logic             valid_q, valid_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             c_q, c_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             sub_q, sub_d;
  logic [SEG_MAX:0] res;

  always_comb begin
    res    = seg_add(SEG_MAX'(in_a[K*SEG +: SEG]), SEG_MAX'(in_b[K*SEG +: SEG]), in_c);
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    sub_d   = sub_q;
    if (adv) begin
      valid_d             = in_valid;
      a_d                 = in_a;
      a_d[K*SEG +: SEG]   = res[SEG-1:0];
      b_d                 = in_b;
      // Inputs are zero-extended, so every bit above SEG-1 is either the carry or zero.
      c_d                 = |res[SEG_MAX:SEG];
      amsb_d              = in_amsb;
      bmsb_d              = in_bmsb;
      sub_d               = in_sub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      sub_q   <= sub_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_amsb  = amsb_q;
  assign out_bmsb  = bmsb_q;
  assign out_sub   = sub_q;

endmodule

// File: rtl/addern_pipe.sv
// Pipelined N-bit adder/subtractor, one SEG-bit segment per stage, valid/ready handshake.
// Final stage registers drive s/cout directly; overflow is decoded from registered sign bits.
module addern_pipe
  import addern_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 8
) (
  input logic         clk,
  input logic         rst,
  addern_pipe_if.slave bus
);

  localparam int STAGES = N / SEG;

  if (!params_ok(N, SEG)) begin : g_bad_params
    $error("addern_pipe: N must be a positive multiple of SEG");
  end

  logic         adv;
  logic         valid_v [STAGES+1];
  logic [N-1:0] a_v     [STAGES+1];
  logic [N-1:0] b_v     [STAGES+1];
  logic         c_v     [STAGES+1];
  logic         amsb_v  [STAGES+1];
  logic         bmsb_v  [STAGES+1];
  logic         sub_v   [STAGES+1];
  logic         sticky_q, sticky_d;
  logic         unused_tail;

  // All stages share one enable; bubbles stay in place rather than collapsing.
  assign adv = !bus.out_valid || bus.out_ready;

  assign valid_v[0] = bus.in_valid;
  assign a_v[0]     = bus.a;
  assign b_v[0]     = bus.sub ? ~bus.b : bus.b;
  assign c_v[0]     = bus.sub ? 1'b1 : bus.cin;
  assign amsb_v[0]  = bus.a[N-1];
  assign bmsb_v[0]  = b_v[0][N-1];
  assign sub_v[0]   = bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addern_seg #(.N(N), .SEG(SEG), .K(k)) u_seg (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .in_valid (valid_v[k]),
      .in_a     (a_v[k]),
      .in_b     (b_v[k]),
      .in_c     (c_v[k]),
      .in_amsb  (amsb_v[k]),
      .in_bmsb  (bmsb_v[k]),
      .in_sub   (sub_v[k]),
      .out_valid(valid_v[k+1]),
      .out_a    (a_v[k+1]),
      .out_b    (b_v[k+1]),
      .out_c    (c_v[k+1]),
      .out_amsb (amsb_v[k+1]),
      .out_bmsb (bmsb_v[k+1]),
      .out_sub  (sub_v[k+1])
    );
  end

  assign unused_tail = ^{b_v[STAGES], sub_v[STAGES]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_v[STAGES];
  assign bus.s         = a_v[STAGES];
  assign bus.cout      = c_v[STAGES];
  assign bus.overflow  = (amsb_v[STAGES] == bmsb_v[STAGES]) &&
                         (a_v[STAGES][N-1] != amsb_v[STAGES]);

  // Set takes priority over clear when both happen in one cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.ovf_clr) sticky_d = 1'b0;
    if (bus.out_valid && bus.out_ready && bus.overflow) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addern_pipe.sv
// Scoreboard bench for addern_pipe (N=16, SEG=8): directed vectors with hand-computed results.
module tb_addern_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addern_pipe_if #(.N(16)) bus ();

  addern_pipe #(.N(16), .SEG(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result transfers at the next rising edge when valid and ready are both high here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got s=0x%0h with nothing expected", bus.s);
        end else begin
          e = sb.pop_front();
          chk("res_s", 32'(bus.s), 32'(e.s));
          chk("res_cout", 32'(bus.cout), 32'(e.c));
          chk("res_ovf", 32'(bus.overflow), 32'(e.o));
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input logic [15:0] es, input logic ec, input logic eo);
    bit accepted = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{s: es, c: ec, o: eo});
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: got out_valid=0 for 20 cycles expected 1", name);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Signed overflow on add; latency is two edges.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_stage0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_out", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("sticky_set", 32'(bus.ovf_sticky), 32'd1);
    @(posedge clk);
    #1;

    // Carry ripples across the segment boundary.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    // Subtract with borrow (cin ignored), then subtract with overflow.
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();

    // Backpressure: 4 back-to-back sets, 3-cycle stall after the first result.
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
      end
      begin
        @(negedge clk);
        wait_out_valid("bp_first_result");
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
          chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
          chk("bp_s_held", 32'(bus.s), 32'h2345);
          chk("bp_cout_held", 32'(bus.cout), 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two sets in flight; sticky is currently set.
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Clear collides with an overflowing transfer: set wins.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    wait_out_valid("clr_collision_result");
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1 bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("clr_collision", 32'(bus.ovf_sticky), 32'd1);
    @(posedge clk);
    #1 bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1 bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("clr_plain", 32'(bus.ovf_sticky), 32'd0);

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addern_pipe.md
# addern_pipe

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake. Each SEG-bit segment of the sum is computed in its own register stage, and the carry is passed forward between stages. Alongside the sum it produces carry-out and signed overflow per result, plus a sticky overflow flag. It is the sequential successor to the fixed-width combinational adder instances used in the arithmetic hierarchy, for paths where a wide carry chain cannot close timing in one cycle.

## Interface
Parameters:
- N, 16, operand and sum width; must be a multiple of SEG.
- SEG, 8, segment width (bits added per stage).
- STAGES, N/SEG (derived, localparam), pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts the operand set this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- s  out  N  sum or difference.
- cout  out  1  carry-out; when sub=1, 1 means no borrow.
- overflow  out  1  two's-complement overflow of this result.
- ovf_clr  in  1  clears ovf_sticky.
- ovf_sticky  out  1  set by any transferred result with overflow=1.

## Operation
Arithmetic:
- sub=0: {cout, s} = a + b + cin.
- sub=1: b_eff = ~b, carry-in forced to 1, cin ignored; {cout, s} = a + ~b + 1.
- overflow = (a[N-1] == b_eff[N-1]) && (s[N-1] != a[N-1]), where b_eff = b when sub=0.

Pipeline:
- Stage k (0..STAGES-1) adds segment k of a and b_eff with the carry from stage k-1 (the effective carry-in at stage 0).
- Segments not yet added (>k), together with a[N-1], b_eff[N-1] and sub, travel unmodified with the data.
- Segments already computed (<k) travel with the data as finished sum bits.
- Each stage holds one valid bit.
- Global advance enable: adv = !out_valid || out_ready.
- in_ready = adv. A transfer occurs when in_valid && in_ready.
- When adv=0 every stage holds, including its valid bit. Bubbles are not collapsed.

Sticky flag:
- Sets when out_valid && out_ready && overflow.
- Clears when ovf_clr=1.
- If set and clear occur in the same cycle, set wins.

Reset:
- All stage valid bits, out_valid, s, cout, overflow and ovf_sticky go to 0 on the clock edge with rst=1.
- in_ready is 1 from the first cycle after reset.
- Data in flight when rst is asserted is discarded and never appears at the output.

## Timing
- Latency: an operand set accepted at edge t gives out_valid=1 with its result after edge t+STAGES, with no stalls.
- Throughput: one result per cycle while out_ready=1.
- s, cout and overflow are registered. They stay stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.
- ovf_sticky updates one edge after the qualifying transfer.
- The final stage drives the outputs directly, so there is no extra output register.
- STAGES=1 (SEG=N) degenerates to a single registered adder with the same handshake.

## Structure
- Package addern_pkg:
  - function seg_add(a_seg, b_seg, c) returning {carry, sum};
  - a parameter-legality check (N % SEG == 0, SEG ≥ 1), enforced by elaboration-time assertion in addern_pipe.
- Sub-module addern_seg: one stage. It holds the stage register with valid, the partial operand/sum vector and the carry, and is instantiated STAGES times in a generate loop.
- Top level: sub/b inversion, the adv/in_ready logic, the overflow output decode and the sticky flag.

## Test plan
N=16, SEG=8, so latency is 2.
1. Add with signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> two cycles later s=0x8000, cout=0, overflow=1; ovf_sticky=1 the following cycle.
2. Carry across the segment boundary: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, overflow=0.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0, overflow=0 (cin ignored). Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, overflow=1.
4. Backpressure: stream 4 back-to-back sets with out_ready=0 for 3 cycles after the first result -> in_ready=0 during the stall, outputs held constant, all 4 results delivered in order with none lost or duplicated.
5. Reset mid-operation: assert rst for 1 cycle with 2 sets in flight -> out_valid=0 and ovf_sticky=0 after that edge; no stale result appears in the next 4 cycles.
6. Clear collision: ovf_clr=1 in the same cycle as an overflowing transfer -> ovf_sticky remains 1. A later ovf_clr with no overflowing transfer -> ovf_sticky=0.
